// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart peripheral: register map, STATUS bit
// positions, serialiser/deserialiser state encodings and the divisor default.
package io_uart_pkg;

  // Register offsets relative to the peripheral base address
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVLO  = 2'd2;
  localparam logic [1:0] REG_DIVHI  = 2'd3;

  // STATUS register bit positions
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  // Reset divisor: bit period is divisor+1 clocks
  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd433;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is dropped unless a pop
// happens in the same cycle; a pop from an empty FIFO is ignored.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             popOk;
  logic             pushOk;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_head  = mem[rdPtr];
  assign popOk   = i_pop && !o_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign pushOk  = i_push && (!o_full || popOk);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      if (pushOk && !popOk)      count <= count + CW'(1);
      else if (popOk && !pushOk) count <= count - CW'(1);
    end
  end

  // Storage array needs no reset; the pointers define what is valid
  always_ff @(posedge i_clk) begin
    if (pushOk) mem[wrPtr] <= i_data;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the CPU IO port: register decode, TX/RX FIFOs,
// serialiser and deserialiser with a programmable baud divisor.
// Bus handshake: a write acts once on the first cycle write-active is seen;
// a read returns data combinationally while read-active and its side effects
// (DATA pop, STATUS sticky clear) fire on the cycle after read-active falls.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [7:0]  P_BASE      = 8'h00,
  parameter int          P_DEPTH     = 4,
  parameter logic [15:0] P_DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_dataEn,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_irq
);

  // ---------------- bus decode ----------------
  logic [7:0] regOff;
  logic       hit, readAct, writeAct, writeActQ, writeEdge;
  logic       readActQ, readFall;
  logic [1:0] readOffQ;
  logic [15:0] divReg;
  logic       rxOverrun, frameErr;

  assign regOff    = i_ioAddress - P_BASE;
  assign hit       = i_ioSelect && (regOff < 8'd4);
  assign readAct   = hit && !i_ioNOE;
  assign writeAct  = hit && !i_ioNWE;
  assign writeEdge = writeAct && !writeActQ;
  assign readFall  = readActQ && !readAct;

  // FIFO wiring
  logic       txPush, txPop, txFull, txEmpty;
  logic [7:0] txHead;
  logic       rxPush, rxPopReq, rxFull, rxEmpty;
  logic [7:0] rxHead, rxShift;

  assign txPush   = writeEdge && (regOff[1:0] == REG_DATA);
  assign rxPopReq = readFall && (readOffQ == REG_DATA) && !rxEmpty;

  io_fifo #(.DEPTH(P_DEPTH), .WIDTH(8)) u_txFifo (
    .i_clk(i_clk), .i_resetN(i_resetN), .i_push(txPush), .i_pop(txPop),
    .i_data(i_data), .o_head(txHead), .o_full(txFull), .o_empty(txEmpty)
  );

  io_fifo #(.DEPTH(P_DEPTH), .WIDTH(8)) u_rxFifo (
    .i_clk(i_clk), .i_resetN(i_resetN), .i_push(rxPush), .i_pop(rxPopReq),
    .i_data(rxShift), .o_head(rxHead), .o_full(rxFull), .o_empty(rxEmpty)
  );

  // Strobe history for once-per-access side effects, and divisor writes
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      writeActQ <= 1'b0;
      readActQ  <= 1'b0;
      readOffQ  <= REG_DATA;
      divReg    <= P_DIV_RESET;
    end else begin
      writeActQ <= writeAct;
      readActQ  <= readAct;
      if (readAct) readOffQ <= regOff[1:0];
      if (writeEdge && (regOff[1:0] == REG_DIVLO)) divReg[7:0]  <= i_data;
      if (writeEdge && (regOff[1:0] == REG_DIVHI)) divReg[15:8] <= i_data;
    end
  end

  // ---------------- TX serialiser ----------------
  txState_t   txState, txStateNext;
  logic [15:0] txCnt, txCntNext, txDiv, txDivNext;
  logic [2:0]  txBit, txBitNext;
  logic [7:0]  txShift, txShiftNext;
  logic        txBitDone, txIdle;

  assign txBitDone = (txCnt == txDiv);
  assign txIdle    = txEmpty && (txState == TX_IDLE);

  // TX state and datapath registers
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txDiv   <= '0;
      txBit   <= '0;
      txShift <= '0;
    end else begin
      txState <= txStateNext;
      txCnt   <= txCntNext;
      txDiv   <= txDivNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
    end
  end

  // TX next-state: pop a byte, then start bit, 8 data bits LSB first, stop bit
  always_comb begin
    txStateNext = txState;
    txCntNext   = txCnt;
    txDivNext   = txDiv;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txPop       = 1'b0;
    case (txState)
      TX_IDLE: begin
        if (!txEmpty) begin
          txPop       = 1'b1;
          txDivNext   = divReg;
          txShiftNext = txHead;
          txCntNext   = '0;
          txBitNext   = '0;
          txStateNext = TX_START;
        end
      end
      TX_START: begin
        if (txBitDone) begin
          txCntNext   = '0;
          txStateNext = TX_DATA;
        end else txCntNext = txCnt + 16'd1;
      end
      TX_DATA: begin
        if (txBitDone) begin
          txCntNext   = '0;
          txShiftNext = {1'b0, txShift[7:1]};
          txBitNext   = txBit + 3'd1;
          if (txBit == 3'd7) txStateNext = TX_STOP;
        end else txCntNext = txCnt + 16'd1;
      end
      TX_STOP: begin
        if (txBitDone) begin
          txCntNext   = '0;
          txStateNext = TX_IDLE;
        end else txCntNext = txCnt + 16'd1;
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  // Line level follows state directly so a reset forces it high at once
  always_comb begin
    o_tx = 1'b1;
    if (txState == TX_START)     o_tx = 1'b0;
    else if (txState == TX_DATA) o_tx = txShift[0];
  end

  // ---------------- RX deserialiser ----------------
  rxState_t   rxState, rxStateNext;
  logic        rxSync1, rxSync2, rxPrev;
  logic [15:0] rxCnt, rxCntNext, rxDiv, rxDivNext;
  logic [2:0]  rxBit, rxBitNext;
  logic [7:0]  rxShiftNext;
  logic        overrunSet, frameErrSet;

  // Two-flop synchroniser plus previous-sample flop for edge detection
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= i_rx;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rxState <= RX_IDLE;
      rxCnt   <= '0;
      rxDiv   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
    end else begin
      rxState <= rxStateNext;
      rxCnt   <= rxCntNext;
      rxDiv   <= rxDivNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
    end
  end

  // RX next-state: falling edge, mid-start check, 8 samples, stop-bit verdict
  always_comb begin
    rxStateNext = rxState;
    rxCntNext   = rxCnt;
    rxDivNext   = rxDiv;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxPush      = 1'b0;
    overrunSet  = 1'b0;
    frameErrSet = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (rxPrev && !rxSync2) begin
          rxDivNext   = divReg;
          rxCntNext   = '0;
          rxBitNext   = '0;
          rxStateNext = RX_START;
        end
      end
      RX_START: begin
        if (rxCnt == (rxDiv >> 1)) begin
          rxCntNext   = '0;
          // A start bit that is high again by mid-bit was only a glitch
          rxStateNext = rxSync2 ? RX_IDLE : RX_DATA;
        end else rxCntNext = rxCnt + 16'd1;
      end
      RX_DATA: begin
        if (rxCnt == rxDiv) begin
          rxCntNext   = '0;
          rxShiftNext = {rxSync2, rxShift[7:1]};
          rxBitNext   = rxBit + 3'd1;
          if (rxBit == 3'd7) rxStateNext = RX_STOP;
        end else rxCntNext = rxCnt + 16'd1;
      end
      RX_STOP: begin
        if (rxCnt == rxDiv) begin
          rxCntNext   = '0;
          rxStateNext = RX_IDLE;
          if (rxSync2) begin
            rxPush = 1'b1;
            if (rxFull && !rxPopReq) overrunSet = 1'b1;
          end else frameErrSet = 1'b1;
        end else rxCntNext = rxCnt + 16'd1;
      end
      default: rxStateNext = RX_IDLE;
    endcase
  end

  // Sticky error flags: a new error in the clearing cycle wins
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rxOverrun <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      if (overrunSet) rxOverrun <= 1'b1;
      else if (readFall && (readOffQ == REG_STATUS)) rxOverrun <= 1'b0;
      if (frameErrSet) frameErr <= 1'b1;
      else if (readFall && (readOffQ == REG_STATUS)) frameErr <= 1'b0;
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] statusVal;

  always_comb begin
    statusVal = 8'h00;
    statusVal[ST_RX_AVAIL]   = !rxEmpty;
    statusVal[ST_TX_FULL]    = txFull;
    statusVal[ST_TX_IDLE]    = txIdle;
    statusVal[ST_RX_OVERRUN] = rxOverrun;
    statusVal[ST_FRAME_ERR]  = frameErr;
  end

  // Combinational read data, zero whenever the bus is not reading us
  always_comb begin
    o_data = 8'h00;
    if (readAct) begin
      case (regOff[1:0])
        REG_DATA:   o_data = rxEmpty ? 8'h00 : rxHead;
        REG_STATUS: o_data = statusVal;
        REG_DIVLO:  o_data = divReg[7:0];
        REG_DIVHI:  o_data = divReg[15:8];
        default:    o_data = 8'h00;
      endcase
    end
  end

  assign o_dataEn = readAct;
  assign o_irq    = !rxEmpty;

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: bus driver tasks issue accesses and push the
// expected read data; a read monitor and a TX line monitor pop and compare.
module tb_io_uart;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       ioSelect = 1'b0;
  logic [7:0] ioAddress = 8'h00;
  logic       ioNOE = 1'b1;
  logic       ioNWE = 1'b1;
  logic [7:0] dataIn = 8'h00;
  logic [7:0] dataOut;
  logic       dataEn;
  logic       rxLine, tx, irq;
  logic       loopEn = 1'b0;
  logic       rxDrive = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic [39:0] txExp_q[$];
  logic        txMonEn = 1'b0;

  localparam logic [7:0] A_DATA = 8'h00, A_STAT = 8'h01, A_DLO = 8'h02, A_DHI = 8'h03;

  assign rxLine = loopEn ? tx : rxDrive;

  io_uart dut (
    .i_clk(clk), .i_resetN(resetN), .i_ioSelect(ioSelect), .i_ioAddress(ioAddress),
    .i_ioNOE(ioNOE), .i_ioNWE(ioNWE), .i_data(dataIn), .o_data(dataOut),
    .o_dataEn(dataEn), .i_rx(rxLine), .o_tx(tx), .o_irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic busWrite(input logic [7:0] a, input logic [7:0] d, input int hold = 1);
    ioSelect = 1'b1; ioAddress = a; dataIn = d; ioNWE = 1'b0;
    waitCyc(hold);
    ioNWE = 1'b1; ioSelect = 1'b0;
    waitCyc(1);
  endtask

  task automatic busRead(input logic [7:0] a, input logic [7:0] exp, input string nm,
                         input int hold = 1);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    ioSelect = 1'b1; ioAddress = a; ioNOE = 1'b0;
    waitCyc(hold);
    ioNOE = 1'b1; ioSelect = 1'b0;
    waitCyc(1);
  endtask

  // 8N1 frame at 8 clocks per bit (divisor 7)
  task automatic sendRx(input logic [7:0] d, input logic stopBit);
    rxDrive = 1'b0; waitCyc(8);
    for (int i = 0; i < 8; i++) begin
      rxDrive = d[i]; waitCyc(8);
    end
    rxDrive = stopBit; waitCyc(8);
    rxDrive = 1'b1; waitCyc(16);
  endtask

  // Expected line samples of one frame, 4 clocks per bit
  function automatic logic [39:0] txWave(input logic [7:0] d);
    logic [39:0] w;
    logic        b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      for (int k = 0; k < 4; k++) w[i*4+k] = b;
    end
    return w;
  endfunction

  // read-data monitor: compares on the first cycle of each read strobe
  logic rdPrev = 1'b0;
  always @(negedge clk) begin
    if (dataEn && !rdPrev) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read: got 0x%0h expected none", dataOut);
      end else begin
        logic [7:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 64'(dataOut), 64'(e));
      end
    end
    rdPrev = dataEn;
  end

  // TX line monitor: captures 40 samples from the start-bit fall
  logic txPrev = 1'b1;
  always begin
    @(negedge clk);
    if (txMonEn && txPrev && !tx) begin
      logic [39:0] w;
      w[0] = tx;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        w[i] = tx;
      end
      if (txExp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_tx_frame: got 0x%0h expected none", w);
      end else check("tx_frame_wave", 64'(w), 64'(txExp_q.pop_front()));
    end
    txPrev = tx;
  end

  initial begin
    #2 resetN = 1'b0;
    waitCyc(3);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_dataEn", 64'(dataEn), 64'd0);
    check("rst_data", 64'(dataOut), 64'd0);
    resetN = 1'b1;
    waitCyc(2);

    busRead(A_STAT, 8'h04, "rst_status");
    busRead(A_DLO, 8'hB1, "rst_divlo");
    busRead(A_DHI, 8'h01, "rst_divhi");
    busRead(A_DATA, 8'h00, "rst_data_empty");

    // TX 0xA5 at divisor 3
    busWrite(A_DLO, 8'h03);
    busWrite(A_DHI, 8'h00);
    busRead(A_DLO, 8'h03, "divlo_readback");
    txExp_q.push_back(txWave(8'hA5));
    txMonEn = 1'b1;
    busWrite(A_DATA, 8'hA5);
    waitCyc(60);
    txMonEn = 1'b0;
    busRead(A_STAT, 8'h04, "tx_idle_after_a5");

    // loopback 0x3C at divisor 7
    busWrite(A_DLO, 8'h07);
    loopEn = 1'b1;
    busWrite(A_DATA, 8'h3C);
    waitCyc(120);
    check("loop_irq", 64'(irq), 64'd1);
    busRead(A_STAT, 8'h05, "loop_status_avail");
    busRead(A_DATA, 8'h3C, "loop_data");
    busRead(A_STAT, 8'h04, "loop_status_empty");
    check("loop_irq_clear", 64'(irq), 64'd0);
    loopEn = 1'b0;

    // overrun: five bytes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) sendRx(8'(i), 1'b1);
    busRead(A_STAT, 8'h0D, "overrun_status");
    busRead(A_STAT, 8'h05, "overrun_cleared");
    for (int i = 1; i <= 4; i++) busRead(A_DATA, 8'(i), "overrun_data");
    busRead(A_DATA, 8'h00, "overrun_empty");
    busRead(A_STAT, 8'h04, "overrun_drained");

    // framing error and 1-clock glitch
    sendRx(8'h55, 1'b0);
    busRead(A_STAT, 8'h14, "frame_err_status");
    busRead(A_STAT, 8'h04, "frame_err_cleared");
    rxDrive = 1'b0; waitCyc(1); rxDrive = 1'b1;
    waitCyc(120);
    busRead(A_STAT, 8'h04, "glitch_ignored");

    // held strobes: one push per write, one pop per read
    loopEn = 1'b1;
    busWrite(A_DATA, 8'h11, 5);
    busWrite(A_DATA, 8'h22);
    waitCyc(300);
    busRead(A_DATA, 8'h11, "held_read_first", 5);
    busRead(A_DATA, 8'h22, "held_single_pop");
    busRead(A_DATA, 8'h00, "held_single_push");
    loopEn = 1'b0;

    // reset in the middle of a frame
    busWrite(A_DATA, 8'h00);
    waitCyc(20);
    check("midframe_tx_low", 64'(tx), 64'd0);
    resetN = 1'b0;
    #1;
    check("midframe_reset_tx", 64'(tx), 64'd1);
    waitCyc(2);
    resetN = 1'b1;
    waitCyc(2);
    busRead(A_STAT, 8'h04, "post_reset_status");
    busRead(A_DLO, 8'hB1, "post_reset_divlo");
    busRead(A_DHI, 8'h01, "post_reset_divhi");

    for (int i = 0; i < 1000 && (exp_q.size() != 0 || txExp_q.size() != 0); i++)
      @(posedge clk);
    if (exp_q.size() != 0 || txExp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending_expectations: got %0d left expected 0",
               exp_q.size() + txExp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
